spi_crc_arbiter: RTL and testbench
==================================

SPI_CRC_ARBITER -- requirements
Module: spi_crc_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one SPI-with-CRC master/slave link; legal values are 2 to 8.
REQ-002 Parameter MAX_RETRY, default 3: maximum retransmissions of one byte after a CRC error.
REQ-003 Parameter TIMEOUT, default 1023: clk cycles allowed per attempt before abort.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester transfer request, level.
REQ-007 din_flat  input  8*N_REQ  byte i at bits [8i+7:8i].
REQ-008 ack  output  N_REQ  one-cycle pulse: byte of requester i delivered CRC-clean.
REQ-009 nack  output  N_REQ  one-cycle pulse: byte of requester i failed (retries exhausted or timeout).
REQ-010 grant_id  output  clog2(N_REQ)  index of the requester currently owning the link.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 newd  output  1  start strobe to the SPI master.
REQ-013 dout  output  8  byte presented to the SPI master din.
REQ-014 done_sending  input  1  from master: frame shifted out.
REQ-015 done_receiving  input  1  from slave: frame received, err valid.
REQ-016 err  input  1  from slave: CRC mismatch, sampled only with done_receiving.

Function
REQ-017 FSM states: IDLE, ARB, LAUNCH, WAIT_TX, WAIT_RX, CHECK, DONE.
REQ-018 IDLE -> ARB when any req bit is high; otherwise remain in IDLE.
REQ-019 ARB: round-robin; the search starts at (last granted + 1) mod N_REQ; after reset the search starts at 0; latch grant_id and the granted byte into dout; -> LAUNCH; 1 cycle.
REQ-020 LAUNCH: newd high for exactly this one cycle; clear the timeout counter; -> WAIT_TX.
REQ-021 WAIT_TX: -> WAIT_RX on the first cycle done_sending is high.
REQ-022 WAIT_RX: -> CHECK on the first cycle done_receiving is high; capture err in that same cycle.
REQ-023 Timeout counter increments every cycle in WAIT_TX/WAIT_RX; reaching TIMEOUT forces nack[grant_id] and -> DONE.
REQ-024 CHECK: if err=0, pulse ack[grant_id] and -> DONE; error handling is per REQ-032/033.
REQ-025 DONE: one cycle; -> IDLE. This guarantees a minimum gap of one cycle between a requester's ack/nack and its next grant.
REQ-026 Minimum request-to-newd latency is 2 cycles (IDLE sample, ARB, then newd in LAUNCH).
REQ-027 dout and grant_id stay stable from ARB until DONE exits; changes on din_flat during that window are ignored.
REQ-028 Deassertion of req by the owner mid-transfer does not abort the transfer; ack or nack is still issued.
REQ-029 If done_sending and done_receiving are both high in the WAIT_TX cycle, the FSM goes to WAIT_RX and that done_receiving is taken as valid in the next cycle only if it is still high.
REQ-030 At most one bit of ack|nack is high in any cycle.

Reset
REQ-031 While rst=0, asynchronously: state=IDLE, newd=0, dout=0, grant_id=0, ack=0, nack=0, busy=0, retry counter=0, timeout counter=0, round-robin pointer set so the next search starts at 0. Assertion mid-transfer abandons the byte with no ack/nack; the first grant after release follows REQ-019.

Configuration
REQ-032 With macro SPI_CRC_RETRY_EN defined: in CHECK with err=1 and retry count < MAX_RETRY, increment the retry count and -> LAUNCH with the same dout; otherwise pulse nack and -> DONE. The retry count clears in ARB.
REQ-033 Without SPI_CRC_RETRY_EN: in CHECK with err=1, pulse nack[grant_id] immediately and -> DONE; no retry counter is implemented.

Verification
REQ-034 req=4'b0001, din0=8'hA5, err=0 -> newd 2 cycles after req, dout=8'hA5, ack=4'b0001 pulse, busy low after DONE.
REQ-035 req=4'b1111 held continuously, no errors -> grant order 0,1,2,3,0; each requester receives exactly one ack per round.
REQ-036 With SPI_CRC_RETRY_EN, err=1 on the first 2 attempts then 0 -> 3 newd pulses all with the same dout, then ack; with err=1 on 4 attempts -> nack after the 4th.
REQ-037 Without SPI_CRC_RETRY_EN, err=1 -> exactly 1 newd pulse, then nack.
REQ-038 done_sending held 0, TIMEOUT=15 -> nack exactly 15 cycles after WAIT_TX entry.
REQ-039 rst pulled low during WAIT_RX -> all outputs 0 in that same cycle; no ack/nack is issued; after release, req=4'b0100 is granted with grant_id=2.

Source files
------------

// File: rtl/spi_crc_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one SPI link with CRC-checked frames.
// Define SPI_CRC_RETRY_EN to retransmit a byte up to MAX_RETRY times after a CRC error.
module spi_crc_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 1023,
    localparam int GW       = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] din_flat,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   nack,
    output logic [GW-1:0]      grant_id,
    output logic               busy,
    output logic               newd,
    output logic [7:0]         dout,
    input  logic               done_sending,
    input  logic               done_receiving,
    input  logic               err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LAUNCH,
        WAIT_TX,
        WAIT_RX,
        CHECK,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   arb_idx;
    logic            arb_found;
    logic [TW-1:0]   tcnt;
    logic            timed_out;
    logic            err_q;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_REQ;
        return s[GW-1:0];
    endfunction

    // Scan downwards so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[wrap_idx(rr_ptr, i)]) begin
                arb_found = 1'b1;
                arb_idx   = wrap_idx(rr_ptr, i);
            end
        end
    end

    assign timed_out = (tcnt == TW'(TIMEOUT));

`ifdef SPI_CRC_RETRY_EN
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic [RW-1:0] retry_cnt;
    logic          can_retry;

    assign can_retry = (retry_cnt < RW'(MAX_RETRY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt <= '0;
        end else if (state == ARB) begin
            retry_cnt <= '0;
        end else if (state == CHECK && err_q && can_retry) begin
            retry_cnt <= retry_cnt + RW'(1);
        end
    end
`else
    logic unused_max_retry;
    assign unused_max_retry = (MAX_RETRY != 0);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        newd      = 1'b0;
        ack       = '0;
        nack      = '0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (|req) state_nxt = ARB;
            end
            ARB: begin
                // Request withdrawn between IDLE sample and arbitration: nothing to launch.
                state_nxt = arb_found ? LAUNCH : IDLE;
            end
            LAUNCH: begin
                newd      = 1'b1;
                state_nxt = WAIT_TX;
            end
            WAIT_TX: begin
                if (timed_out) begin
                    nack[grant_id] = 1'b1;
                    state_nxt      = DONE;
                end else if (done_sending) begin
                    state_nxt = WAIT_RX;
                end
            end
            WAIT_RX: begin
                if (timed_out) begin
                    nack[grant_id] = 1'b1;
                    state_nxt      = DONE;
                end else if (done_receiving) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (!err_q) begin
                    ack[grant_id] = 1'b1;
                    state_nxt     = DONE;
`ifdef SPI_CRC_RETRY_EN
                end else if (can_retry) begin
                    state_nxt = LAUNCH;
`endif
                end else begin
                    nack[grant_id] = 1'b1;
                    state_nxt      = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant, byte and pointer are latched only in ARB so they hold for the whole transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_id <= '0;
            dout     <= '0;
            rr_ptr   <= '0;
            tcnt     <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state == ARB && arb_found) begin
                grant_id <= arb_idx;
                dout     <= din_flat[{arb_idx, 3'b000} +: 8];
                rr_ptr   <= wrap_idx(arb_idx, 1);
            end
            if (state == LAUNCH) begin
                tcnt <= '0;
            end else if (state == WAIT_TX || state == WAIT_RX) begin
                tcnt <= tcnt + TW'(1);
            end
            if (state == WAIT_RX && done_receiving) begin
                err_q <= err;
            end
        end
    end

endmodule

// File: tb/tb_spi_crc_arbiter.sv
// Directed self-checking bench for spi_crc_arbiter (4 requesters, TIMEOUT=15).
module tb_spi_crc_arbiter;

    localparam int N_REQ     = 4;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din_flat;
    logic [3:0]  ack;
    logic [3:0]  nack;
    logic [1:0]  grant_id;
    logic        busy;
    logic        newd;
    logic [7:0]  dout;
    logic        done_sending;
    logic        done_receiving;
    logic        err;

    int checks = 0;
    int errors = 0;

    int         rr_order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] rr_bytes [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    always #5 clk = ~clk;

    spi_crc_arbiter #(
        .N_REQ    (N_REQ),
        .MAX_RETRY(MAX_RETRY),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .din_flat      (din_flat),
        .ack           (ack),
        .nack          (nack),
        .grant_id      (grant_id),
        .busy          (busy),
        .newd          (newd),
        .dout          (dout),
        .done_sending  (done_sending),
        .done_receiving(done_receiving),
        .err           (err)
    );

    task automatic wait_launch(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (newd === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // From the LAUNCH cycle: one WAIT_TX cycle, one WAIT_RX cycle, ends sampled in CHECK.
    task automatic complete(input logic e);
        @(negedge clk);
        done_sending = 1'b1;
        @(negedge clk);
        done_sending   = 1'b0;
        done_receiving = 1'b1;
        err            = e;
        @(negedge clk);
        done_receiving = 1'b0;
        err            = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req = '0; din_flat = '0;
        done_sending = 1'b0; done_receiving = 1'b0; err = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (newd !== 1'b0) begin errors++; $display("FAIL reset_newd got=%b exp=0", newd); end
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        checks++; if ((ack | nack) !== 4'b0000) begin errors++; $display("FAIL reset_acknack got=%b/%b exp=0000/0000", ack, nack); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        din_flat = 32'h4433_22A5;
        req      = 4'b0001;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || newd !== 1'b0) begin errors++; $display("FAIL single_arb busy/newd got=%b/%b exp=1/0", busy, newd); end
        @(negedge clk);
        checks++; if (newd !== 1'b1) begin errors++; $display("FAIL single_latency newd got=%b exp=1", newd); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL single_dout got=%h exp=a5", dout); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
        req      = 4'b0000;
        din_flat = 32'h4433_225A;
        complete(1'b0);
        checks++; if (ack !== 4'b0001 || nack !== 4'b0000) begin errors++; $display("FAIL single_ack got=%b/%b exp=0001/0000", ack, nack); end
        checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL single_dout_hold got=%h exp=a5", dout); end
        @(negedge clk);
        checks++; if (ack !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_done ack/busy got=%b/%b exp=0000/1", ack, busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_round_robin();
        int   ack_cnt [4];
        logic ok;
        for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
        do_reset();
        din_flat = 32'hD3C2_B1A0;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_launch(ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_launch_%0d got=none exp=newd", k); end
            checks++; if (grant_id !== 2'(rr_order[k])) begin errors++; $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, grant_id, rr_order[k]); end
            checks++; if (dout !== rr_bytes[rr_order[k]]) begin errors++; $display("FAIL rr_dout_%0d got=%h exp=%h", k, dout, rr_bytes[rr_order[k]]); end
            if (k == 4) req = 4'b0000;
            complete(1'b0);
            checks++; if (ack !== (4'b0001 << rr_order[k]) || nack !== 4'b0000) begin errors++; $display("FAIL rr_ack_%0d got=%b/%b exp=%b/0000", k, ack, nack, 4'b0001 << rr_order[k]); end
            for (int r = 0; r < 4; r++) if (ack[r] === 1'b1) ack_cnt[r]++;
            if (k == 3) begin
                for (int r = 0; r < 4; r++) begin
                    checks++; if (ack_cnt[r] != 1) begin errors++; $display("FAIL rr_round_acks_%0d got=%0d exp=1", r, ack_cnt[r]); end
                end
            end
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef SPI_CRC_RETRY_EN
    task automatic test_retry();
        logic ok;
        int   nd = 0;
        din_flat = 32'h0000_3C00 << 8;
        req      = 4'b0100;
        for (int a = 0; a < 3; a++) begin
            wait_launch(ok);
            if (ok) nd++;
            checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL retry_dout_%0d got=%h exp=3c", a, dout); end
            complete(a < 2);
            if (a < 2) begin
                checks++; if ((ack | nack) !== 4'b0000) begin errors++; $display("FAIL retry_mid_%0d got=%b/%b exp=0000/0000", a, ack, nack); end
            end else begin
                checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL retry_ack got=%b exp=0100", ack); end
            end
        end
        req = 4'b0000;
        checks++; if (nd != 3) begin errors++; $display("FAIL retry_newd_count got=%0d exp=3", nd); end
        repeat (2) @(negedge clk);
        nd  = 0;
        req = 4'b0100;
        for (int a = 0; a < 4; a++) begin
            wait_launch(ok);
            if (ok) nd++;
            complete(1'b1);
            if (a < 3) begin
                checks++; if ((ack | nack) !== 4'b0000) begin errors++; $display("FAIL retry_exh_mid_%0d got=%b/%b exp=0000/0000", a, ack, nack); end
            end else begin
                checks++; if (nack !== 4'b0100 || ack !== 4'b0000) begin errors++; $display("FAIL retry_exh_nack got=%b/%b exp=0100/0000", nack, ack); end
            end
        end
        req = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (newd === 1'b1) nd++;
        end
        checks++; if (nd != 4) begin errors++; $display("FAIL retry_exh_newd_count got=%0d exp=4", nd); end
    endtask
`else
    task automatic test_no_retry();
        logic ok;
        int   nd = 0;
        din_flat = 32'h0000_7700;
        req      = 4'b0010;
        wait_launch(ok);
        if (ok) nd++;
        checks++; if (grant_id !== 2'd1 || dout !== 8'h77) begin errors++; $display("FAIL noretry_grant got=%0d/%h exp=1/77", grant_id, dout); end
        complete(1'b1);
        checks++; if (nack !== 4'b0010 || ack !== 4'b0000) begin errors++; $display("FAIL noretry_nack got=%b/%b exp=0010/0000", nack, ack); end
        req = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (newd === 1'b1) nd++;
        end
        checks++; if (nd != 1) begin errors++; $display("FAIL noretry_newd_count got=%0d exp=1", nd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL noretry_idle busy got=%b exp=0", busy); end
    endtask
`endif

    task automatic test_timeout();
        logic ok;
        int   early = 0;
        din_flat = 32'hE100_0000;
        req      = 4'b1000;
        wait_launch(ok);
        checks++; if (!ok || grant_id !== 2'd3) begin errors++; $display("FAIL timeout_launch got=%b/%0d exp=1/3", ok, grant_id); end
        @(negedge clk);
        for (int j = 1; j <= 15; j++) begin
            @(negedge clk);
            if (j < 15) begin
                if ((ack | nack) !== 4'b0000) early++;
            end else begin
                checks++; if (nack !== 4'b1000 || ack !== 4'b0000) begin errors++; $display("FAIL timeout_nack got=%b/%b exp=1000/0000", nack, ack); end
                req = 4'b0000;
            end
        end
        checks++; if (early != 0) begin errors++; $display("FAIL timeout_early got=%0d exp=0", early); end
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic ok;
        din_flat = 32'h0000_0066;
        req      = 4'b0001;
        wait_launch(ok);
        checks++; if (!ok || grant_id !== 2'd0) begin errors++; $display("FAIL b2b_launch got=%b/%0d exp=1/0", ok, grant_id); end
        @(negedge clk);
        done_sending = 1'b1; done_receiving = 1'b1; err = 1'b1;
        @(negedge clk);
        done_sending = 1'b0; done_receiving = 1'b0; err = 1'b0;
        @(negedge clk);
        checks++; if ((ack | nack) !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%b/%b busy=%b exp=0000/0000 busy=1", ack, nack, busy); end
        done_receiving = 1'b1;
        req            = 4'b0000;
        @(negedge clk);
        done_receiving = 1'b0;
        checks++; if (ack !== 4'b0001 || nack !== 4'b0000) begin errors++; $display("FAIL b2b_ack got=%b/%b exp=0001/0000", ack, nack); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mid_reset();
        logic ok;
        int   stray = 0;
        din_flat = 32'h0099_0011;
        req      = 4'b0001;
        wait_launch(ok);
        @(negedge clk);
        done_sending = 1'b1;
        @(negedge clk);
        done_sending = 1'b0;
        #1 rst = 1'b0;
        #1;
        checks++; if ({newd, busy, dout, grant_id, ack, nack} !== 20'd0) begin errors++; $display("FAIL midrst_outputs got=%b %b %h %0d %b %b exp=all0", newd, busy, dout, grant_id, ack, nack); end
        req            = 4'b0100;
        done_receiving = 1'b1;
        @(negedge clk);
        if ((ack | nack) !== 4'b0000) stray++;
        rst            = 1'b1;
        done_receiving = 1'b0;
        wait_launch(ok);
        checks++; if (!ok || grant_id !== 2'd2 || dout !== 8'h99) begin errors++; $display("FAIL midrst_grant got=%b/%0d/%h exp=1/2/99", ok, grant_id, dout); end
        req = 4'b0000;
        complete(1'b0);
        checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL midrst_ack got=%b exp=0100", ack); end
        checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray got=%0d exp=0", stray); end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
`ifdef SPI_CRC_RETRY_EN
        test_retry();
`else
        test_no_retry();
`endif
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
